time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl (with helper time_set_debounce)
// Purpose  : Two-key MM:SS time-setting controller: key debounce, edit FSM, load strobe.
//            Optional macro TIME_SET_AUTO_REPEAT_EN adds 1 Hz auto-repeat on a held inc key.
// Revision : 1.0 - initial release
// ============================================================================

module time_set_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk_50,
    input  logic rst,
    input  logic i_key,
    output logic o_level
);
    localparam int              CW        = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   c_CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_key;
            r_s2 <= r_s1;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
endmodule

module time_set_ctrl #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       tick_1hz,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_MIN = 2'b01,
        ST_SET_SEC = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_mode_lvl;
    logic       w_inc_lvl;
    logic       r_mode_lvl_d;
    logic       r_inc_lvl_d;
    logic       w_mode_evt;
    logic       w_inc_evt;
    logic       w_rep_inc;
    logic       w_do_inc;
    logic       w_editing;
    logic       r_load;
    logic       r_blink;
    logic [5:0] r_load_min;
    logic [5:0] r_load_sec;
    logic [5:0] w_min_cap;
    logic [5:0] w_sec_cap;
    logic [5:0] w_min_inc;
    logic [5:0] w_sec_inc;

    time_set_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk_50  (clk_50),
        .rst     (rst),
        .i_key   (key_mode),
        .o_level (w_mode_lvl)
    );

    time_set_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk_50  (clk_50),
        .rst     (rst),
        .i_key   (key_inc),
        .o_level (w_inc_lvl)
    );

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_mode_lvl_d <= 1'b1;
            r_inc_lvl_d  <= 1'b1;
        end else begin
            r_mode_lvl_d <= w_mode_lvl;
            r_inc_lvl_d  <= w_inc_lvl;
        end
    end

    // Keys are active-low: only the debounced press (1->0) is an event.
    assign w_mode_evt = r_mode_lvl_d & ~w_mode_lvl;
    assign w_inc_evt  = r_inc_lvl_d  & ~w_inc_lvl;
    assign w_editing  = (r_state != ST_RUN);

`ifdef TIME_SET_AUTO_REPEAT_EN
    logic r_rep_arm;

    // First tick after a press only arms; every later tick while held repeats.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_rep_arm <= 1'b0;
        end else if (w_inc_evt || w_inc_lvl || !w_editing) begin
            r_rep_arm <= 1'b0;
        end else if (tick_1hz) begin
            r_rep_arm <= 1'b1;
        end
    end

    assign w_rep_inc = tick_1hz & r_rep_arm & ~w_inc_lvl & w_editing;
`else
    assign w_rep_inc = 1'b0;
`endif

    assign w_do_inc  = (w_inc_evt | w_rep_inc) & ~w_mode_evt;
    assign w_min_cap = (cur_min > 6'd59) ? 6'd0 : cur_min;
    assign w_sec_cap = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
    assign w_min_inc = (r_load_min >= 6'd59) ? 6'd0 : r_load_min + 6'd1;
    assign w_sec_inc = (r_load_sec >= 6'd59) ? 6'd0 : r_load_sec + 6'd1;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_mode_evt) begin
            case (r_state)
                ST_RUN:     w_next = ST_SET_MIN;
                ST_SET_MIN: w_next = ST_SET_SEC;
                default:    w_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_load     <= 1'b0;
            r_load_min <= 6'd0;
            r_load_sec <= 6'd0;
            r_blink    <= 1'b0;
        end else begin
            r_load <= (r_state == ST_SET_SEC) && w_mode_evt;

            if ((r_state == ST_RUN) && w_mode_evt) begin
                r_load_min <= w_min_cap;
                r_load_sec <= w_sec_cap;
            end else if (w_do_inc && (r_state == ST_SET_MIN)) begin
                r_load_min <= w_min_inc;
            end else if (w_do_inc && (r_state == ST_SET_SEC)) begin
                r_load_sec <= w_sec_inc;
            end

            if (w_mode_evt || !w_editing) begin
                r_blink <= 1'b0;
            end else if (tick_1hz) begin
                r_blink <= ~r_blink;
            end
        end
    end

    assign run_en   = (r_state == ST_RUN);
    assign load     = r_load;
    assign load_min = r_load_min;
    assign load_sec = r_load_sec;
    assign mode     = r_state;
    assign blink    = r_blink;
endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Purpose  : Directed vector table plus hand sequences for time_set_ctrl (DB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;
    localparam int OP_MODE = 0;
    localparam int OP_INC  = 1;
    localparam int OP_BOTH = 2;

    typedef struct {
        int op;
        int cmin;
        int csec;
        int emode;
        int erun;
        int elm;
        int els;
        int eloads;
    } vec_t;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic       key_mode;
    logic       key_inc;
    logic       tick_1hz;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       run_en;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [1:0] mode;
    logic       blink;

    int n_tests   = 0;
    int n_fail    = 0;
    int load_cnt  = 0;
    int mode_chg  = 0;
    int last_lm   = -1;
    int last_ls   = -1;
    int prev_mode = 0;
    int exp_rep;

    vec_t vt[22];

    time_set_ctrl #(.DB_CYCLES(4)) dut (
        .clk_50   (clk_50),
        .rst      (rst),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .tick_1hz (tick_1hz),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .run_en   (run_en),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (load === 1'b1) begin
            load_cnt++;
            last_lm = int'(load_min);
            last_ls = int'(load_sec);
        end
        if (int'(mode) != prev_mode) mode_chg++;
        prev_mode = int'(mode);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int op);
        @(negedge clk_50);
        if (op == OP_MODE || op == OP_BOTH) key_mode = 1'b0;
        if (op == OP_INC  || op == OP_BOTH) key_inc  = 1'b0;
        repeat (12) @(negedge clk_50);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (12) @(negedge clk_50);
    endtask

    task automatic pulse_tick();
        @(negedge clk_50);
        tick_1hz = 1'b1;
        @(negedge clk_50);
        tick_1hz = 1'b0;
    endtask

    initial begin
        // Starts in SET_MIN with 12:34 captured by the bounce sequence.
        vt[0]  = '{OP_INC,   0,  0, 1, 0, 13, 34, 0};
        vt[1]  = '{OP_MODE,  0,  0, 2, 0, 13, 34, 0};
        vt[2]  = '{OP_INC,   0,  0, 2, 0, 13, 35, 0};
        vt[3]  = '{OP_MODE,  0,  0, 0, 1, 13, 35, 1};
        vt[4]  = '{OP_INC,   0,  0, 0, 1, 13, 35, 1};
        vt[5]  = '{OP_MODE, 10, 50, 1, 0, 10, 50, 1};
        vt[6]  = '{OP_INC,  10, 50, 1, 0, 11, 50, 1};
        vt[7]  = '{OP_INC,  10, 50, 1, 0, 12, 50, 1};
        vt[8]  = '{OP_INC,  10, 50, 1, 0, 13, 50, 1};
        vt[9]  = '{OP_MODE, 10, 50, 2, 0, 13, 50, 1};
        vt[10] = '{OP_INC,  10, 50, 2, 0, 13, 51, 1};
        vt[11] = '{OP_INC,  10, 50, 2, 0, 13, 52, 1};
        vt[12] = '{OP_MODE, 10, 50, 0, 1, 13, 52, 2};
        vt[13] = '{OP_MODE, 59, 20, 1, 0, 59, 20, 2};
        vt[14] = '{OP_INC,  59, 20, 1, 0,  0, 20, 2};
        vt[15] = '{OP_BOTH, 59, 20, 2, 0,  0, 20, 2};
        vt[16] = '{OP_MODE, 59, 20, 0, 1,  0, 20, 3};
        vt[17] = '{OP_MODE, 63, 61, 1, 0,  0,  0, 3};
        vt[18] = '{OP_INC,  63, 61, 1, 0,  1,  0, 3};
        vt[19] = '{OP_MODE, 63, 61, 2, 0,  1,  0, 3};
        vt[20] = '{OP_MODE, 63, 61, 0, 1,  1,  0, 4};
        vt[21] = '{OP_MODE,  5,  6, 1, 0,  5,  6, 4};

        rst = 1'b1; key_mode = 1'b1; key_inc = 1'b1; tick_1hz = 1'b0;
        cur_min = 6'd0; cur_sec = 6'd0;
        repeat (3) @(posedge clk_50);
        #1;
        chk("reset mode",     int'(mode),     0);
        chk("reset run_en",   int'(run_en),   1);
        chk("reset load",     int'(load),     0);
        chk("reset load_min", int'(load_min), 0);
        chk("reset load_sec", int'(load_sec), 0);
        chk("reset blink",    int'(blink),    0);
        @(negedge clk_50);
        rst = 1'b0;
        repeat (4) @(negedge clk_50);
        mode_chg = 0;

        // Bouncy mode key: only the final sustained low may count.
        cur_min = 6'd12; cur_sec = 6'd34;
        key_mode = 1'b0; @(negedge clk_50);
        key_mode = 1'b1; @(negedge clk_50);
        key_mode = 1'b0; @(negedge clk_50);
        key_mode = 1'b1; @(negedge clk_50);
        key_mode = 1'b0;
        repeat (10) @(negedge clk_50);
        key_mode = 1'b1;
        repeat (12) @(negedge clk_50);
        chk("bounce mode events", mode_chg,       1);
        chk("bounce mode",        int'(mode),     1);
        chk("bounce run_en",      int'(run_en),   0);
        chk("bounce load_min",    int'(load_min), 12);
        chk("bounce load_sec",    int'(load_sec), 34);

        for (int i = 0; i < 22; i++) begin
            cur_min = 6'(vt[i].cmin);
            cur_sec = 6'(vt[i].csec);
            press(vt[i].op);
            chk($sformatf("v%0d mode", i),     int'(mode),     vt[i].emode);
            chk($sformatf("v%0d run_en", i),   int'(run_en),   vt[i].erun);
            chk($sformatf("v%0d load_min", i), int'(load_min), vt[i].elm);
            chk($sformatf("v%0d load_sec", i), int'(load_sec), vt[i].els);
            chk($sformatf("v%0d loads", i),    load_cnt,       vt[i].eloads);
            if (i == 12) begin
                chk("v12 loaded min", last_lm, 13);
                chk("v12 loaded sec", last_ls, 52);
            end
        end

        // Asynchronous reset mid-edit aborts without a load pulse.
        @(negedge clk_50);
        #2 rst = 1'b1;
        #1;
        chk("midreset mode",     int'(mode),     0);
        chk("midreset run_en",   int'(run_en),   1);
        chk("midreset load_min", int'(load_min), 0);
        repeat (2) @(negedge clk_50);
        rst = 1'b0;
        repeat (5) @(negedge clk_50);
        chk("post-reset mode",   int'(mode),   0);
        chk("post-reset run_en", int'(run_en), 1);
        chk("post-reset loads",  load_cnt,     4);

        pulse_tick();
        chk("blink in RUN", int'(blink), 0);
        cur_min = 6'd0; cur_sec = 6'd0;
        press(OP_MODE);
        chk("blink after enter", int'(blink), 0);
        pulse_tick();
        chk("blink tick1", int'(blink), 1);
        pulse_tick();
        chk("blink tick2", int'(blink), 0);
        pulse_tick();
        chk("blink tick3", int'(blink), 1);
        press(OP_MODE);
        chk("blink cleared on mode", int'(blink),    0);
        chk("set_sec start",         int'(load_sec), 0);

        // Held inc key: one tick lands during debounce, three after the press.
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_rep = 3;
`else
        exp_rep = 1;
`endif
        @(negedge clk_50);
        key_inc = 1'b0;
        repeat (2) @(negedge clk_50);
        pulse_tick();
        repeat (10) @(negedge clk_50);
        for (int t = 0; t < 3; t++) begin
            pulse_tick();
            repeat (4) @(negedge clk_50);
        end
        key_inc = 1'b1;
        repeat (12) @(negedge clk_50);
        chk("held inc load_sec", int'(load_sec), exp_rep);
        press(OP_MODE);
        chk("final mode",       int'(mode),   0);
        chk("final loads",      load_cnt,     5);
        chk("final loaded sec", last_ls,      exp_rep);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
